// File: rtl/onehot_bin_enc_if.sv
// Stream bundle for the one-hot to binary encoder.
// slave is the encoder's view, master is the upstream/downstream view.
interface onehot_bin_enc_if #(
    parameter int WIDTH = 16,
    parameter int BIN_W = $clog2(WIDTH),
    parameter int CNT_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] one_hot_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [BIN_W-1:0] bin_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;

    modport slave (
        input  in_valid_i,
        input  one_hot_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output bin_o,
        output err_o,
        output err_cnt_o
    );

    modport master (
        output in_valid_i,
        output one_hot_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  bin_o,
        input  err_o,
        input  err_cnt_o
    );
endinterface

// File: rtl/onehot_bin_enc.sv
// One-hot to binary encoder with illegal-word flag and error counter.
// Valid/ready on both sides; output register plus one skid entry.
module onehot_bin_enc #(
    parameter int WIDTH = 16,
    parameter int BIN_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    onehot_bin_enc_if.slave    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [BIN_W-1:0] out_bin_q;
    logic [BIN_W-1:0] out_bin_d;
    logic             out_err_q;
    logic             out_err_d;
    logic [BIN_W-1:0] skid_bin_q;
    logic [BIN_W-1:0] skid_bin_d;
    logic             skid_err_q;
    logic             skid_err_d;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic             in_rdy;
    logic             out_vld;
    logic             accept;
    logic             take;
    logic [BIN_W-1:0] enc_bin;
    logic             enc_err;
    logic [WIDTH-1:0] word;

    assign word    = bus.one_hot_i;
    assign in_rdy  = reset & (state_q != FULL);
    assign out_vld = (state_q != EMPTY);
    assign accept  = bus.in_valid_i & in_rdy;
    assign take    = out_vld & bus.out_ready_i;

    // Scan downward so the lowest set bit wins on multi-hot words.
    always_comb begin
        enc_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (word[i]) begin
                enc_bin = BIN_W'(i);
            end
        end
    end

    // Zero or more than one bit set.
    assign enc_err = (word == '0) |
                     ((word & (word - 1'b1)) != '0);

    always_comb begin
        state_d    = state_q;
        out_bin_d  = out_bin_q;
        out_err_d  = out_err_q;
        skid_bin_d = skid_bin_q;
        skid_err_d = skid_err_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_bin_d = enc_bin;
                    out_err_d = enc_err;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (accept && !take) begin
                    skid_bin_d = enc_bin;
                    skid_err_d = enc_err;
                    state_d    = FULL;
                end else if (accept && take) begin
                    out_bin_d = enc_bin;
                    out_err_d = enc_err;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (take) begin
                    out_bin_d = skid_bin_q;
                    out_err_d = skid_err_q;
                    state_d   = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && enc_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= EMPTY;
            out_bin_q  <= '0;
            out_err_q  <= 1'b0;
            skid_bin_q <= '0;
            skid_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_bin_q  <= out_bin_d;
            out_err_q  <= out_err_d;
            skid_bin_q <= skid_bin_d;
            skid_err_q <= skid_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready_o  = in_rdy;
    assign bus.out_valid_o = out_vld;
    assign bus.bin_o       = out_bin_q;
    assign bus.err_o       = out_err_q;
    assign bus.err_cnt_o   = err_cnt_q;

endmodule
